// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch into an in-order queue.
// Redirect flushes the queue and discards responses still in flight.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  ptr_t        rd_q, rd_d;
  ptr_t        wr_q, wr_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] data_mem_q [DEPTH];

  logic [CW:0] used;
  logic        req_fire;
  logic        pop;
  logic        push;
  logic        dropping;

  // Dropped requests still hold credit until their response returns.
  assign used = {1'b0, count_q} + {1'b0, outst_q};

  assign imem_req_valid = !redirect && (used < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc_q;

  assign inst_valid = (count_q != '0) && !redirect;
  assign inst_data  = data_mem_q[rd_q];
  assign inst_pc    = pc_mem_q[rd_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign dropping = (drop_q != '0);
  assign push     = imem_resp_valid && !redirect && !dropping;

  // Next-state for PCs, pointers and counters; redirect overrides all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    outst_d    = outst_q + cnt_t'(req_fire)
               - cnt_t'(imem_resp_valid);
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      drop_d     = outst_q - cnt_t'(imem_resp_valid);
    end else begin
      if (req_fire)
        fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_resp_valid && dropping)
        drop_d = drop_q - cnt_t'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_d      = wr_q + ptr_t'(1);
      end
      if (pop)
        rd_d = rd_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage; PC slots reset to RESET_PC so inst_pc starts there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= RESET_PC;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_q]   <= resp_pc_q;
      data_mem_q[wr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios against a variable-latency
// instruction memory model and a delivered-instruction log.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int ncmp = 0;
  int nfail = 0;
  int lat = 1;
  int cyc = 0;

  logic [31:0] pa_q [$];
  int          pd_q [$];
  logic [31:0] acc_q [$];
  logic [31:0] dpc_q [$];
  logic [31:0] ddat_q [$];

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  // Memory: record accepts and retire responses at the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      pa_q.delete();
      pd_q.delete();
    end else begin
      if (imem_resp_valid) begin
        pa_q.delete(0);
        pd_q.delete(0);
      end
      if (imem_req_valid && imem_req_ready) begin
        pa_q.push_back(imem_req_addr);
        pd_q.push_back(cyc + lat);
        acc_q.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) begin
        dpc_q.push_back(inst_pc);
        ddat_q.push_back(inst_data);
      end
    end
  end

  // Memory: present the oldest response once its latency has elapsed.
  always @(negedge clk) begin
    if (rst && pa_q.size() > 0 && pd_q[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word(pa_q[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    acc_q.delete();
    dpc_q.delete();
    ddat_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    ncmp++; if (imem_req_valid !== 1'b1) begin nfail++;
      $display("FAIL rst_req_valid got %0h exp 1", imem_req_valid); end
    ncmp++; if (imem_req_addr !== 32'h0) begin nfail++;
      $display("FAIL rst_req_addr got %0h exp 0", imem_req_addr); end
    ncmp++; if (inst_valid !== 1'b0) begin nfail++;
      $display("FAIL rst_inst_valid got %0h exp 0", inst_valid); end
    ncmp++; if (inst_data !== 32'h0) begin nfail++;
      $display("FAIL rst_inst_data got %0h exp 0", inst_data); end
    ncmp++; if (inst_pc !== 32'h0) begin nfail++;
      $display("FAIL rst_inst_pc got %0h exp 0", inst_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      #1;
      ncmp++; if (inst_valid !== (c >= 2)) begin nfail++;
        $display("FAIL stream_valid c%0d got %0h exp %0h",
                 c, inst_valid, (c >= 2)); end
      if (c >= 2) begin
        epc = 32'(4 * (c - 2));
        ncmp++; if (inst_pc !== epc) begin nfail++;
          $display("FAIL stream_pc c%0d got %0h exp %0h",
                   c, inst_pc, epc); end
        ncmp++; if (inst_data !== word(epc)) begin nfail++;
          $display("FAIL stream_data c%0d got %0h exp %0h",
                   c, inst_data, word(epc)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] epc;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      #1;
      if (c == 3 || c == 9) begin
        ncmp++; if (inst_pc !== 32'h0) begin nfail++;
          $display("FAIL bp_hold_pc c%0d got %0h exp 0", c, inst_pc); end
      end
    end
    ncmp++; if (acc_q.size() != 4) begin nfail++;
      $display("FAIL bp_accepts got %0d exp 4", acc_q.size()); end
    ncmp++; if (imem_req_valid !== 1'b0) begin nfail++;
      $display("FAIL bp_req_valid got %0h exp 0", imem_req_valid); end
    ncmp++; if (inst_valid !== 1'b1) begin nfail++;
      $display("FAIL bp_inst_valid got %0h exp 1", inst_valid); end
    inst_ready = 1'b1;
    repeat (10) step();
    ncmp++; if (dpc_q.size() < 5) begin nfail++;
      $display("FAIL bp_drained got %0d exp >=5", dpc_q.size()); end
    for (int i = 0; i < 5 && i < dpc_q.size(); i++) begin
      epc = 32'(4 * i);
      ncmp++; if (dpc_q[i] !== epc || ddat_q[i] !== word(epc)) begin
        nfail++;
        $display("FAIL bp_order %0d got %0h/%0h exp %0h/%0h",
                 i, dpc_q[i], ddat_q[i], epc, word(epc)); end
    end
    ncmp++; if (acc_q.size() < 5 || acc_q[4] !== 32'h10) begin nfail++;
      $display("FAIL bp_resume got n=%0d exp addr 10", acc_q.size()); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3;
    inst_ready = 1'b1;
    imem_req_ready = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    ncmp++; if (imem_req_valid !== 1'b0) begin nfail++;
      $display("FAIL rd_req_valid got %0h exp 0", imem_req_valid); end
    ncmp++; if (inst_valid !== 1'b0) begin nfail++;
      $display("FAIL rd_inst_valid got %0h exp 0", inst_valid); end
    step();
    redirect = 1'b0;
    #1;
    ncmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40)
    begin nfail++;
      $display("FAIL rd_next_req got %0h/%0h exp 1/40",
               imem_req_valid, imem_req_addr); end
    repeat (10) step();
    ncmp++; if (acc_q.size() < 3 || acc_q[0] !== 32'h0 ||
                acc_q[1] !== 32'h4 || acc_q[2] !== 32'h40) begin
      nfail++;
      $display("FAIL rd_accepts got n=%0d exp 0,4,40", acc_q.size()); end
    ncmp++; if (dpc_q.size() < 2) begin nfail++;
      $display("FAIL rd_delivered got %0d exp >=2", dpc_q.size()); end
    else begin
      ncmp++; if (dpc_q[0] !== 32'h40 || ddat_q[0] !== word(32'h40))
      begin nfail++;
        $display("FAIL rd_first got %0h/%0h exp 40/%0h",
                 dpc_q[0], ddat_q[0], word(32'h40)); end
      ncmp++; if (dpc_q[1] !== 32'h44) begin nfail++;
        $display("FAIL rd_second got %0h exp 44", dpc_q[1]); end
    end
  endtask

  task automatic test_redirect_resp_pop();
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    step();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    ncmp++; if (inst_valid !== 1'b0) begin nfail++;
      $display("FAIL rp_inst_valid got %0h exp 0", inst_valid); end
    ncmp++; if (imem_req_valid !== 1'b0) begin nfail++;
      $display("FAIL rp_req_valid got %0h exp 0", imem_req_valid); end
    step();
    redirect = 1'b0;
    #1;
    ncmp++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1)
    begin nfail++;
      $display("FAIL rp_next_req got %0h/%0h exp 1/100",
               imem_req_valid, imem_req_addr); end
    ncmp++; if (inst_valid !== 1'b0) begin nfail++;
      $display("FAIL rp_gap_valid got %0h exp 0", inst_valid); end
    repeat (6) step();
    ncmp++; if (dpc_q.size() < 3 || dpc_q[0] !== 32'h0 ||
                dpc_q[1] !== 32'h100 || dpc_q[2] !== 32'h104 ||
                ddat_q[1] !== word(32'h100)) begin
      nfail++;
      $display("FAIL rp_sequence got n=%0d exp 0,100,104",
               dpc_q.size()); end
  endtask

  task automatic test_random_ready();
    logic [31:0] epc;
    do_reset();
    lat = 2;
    for (int c = 0; c < 200; c++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    repeat (20) step();
    ncmp++; if (dpc_q.size() < 20) begin nfail++;
      $display("FAIL rnd_count got %0d exp >=20", dpc_q.size()); end
    for (int i = 0; i < dpc_q.size(); i++) begin
      epc = 32'(4 * i);
      ncmp++; if (dpc_q[i] !== epc || ddat_q[i] !== word(epc)) begin
        nfail++;
        $display("FAIL rnd_seq %0d got %0h/%0h exp %0h/%0h",
                 i, dpc_q[i], ddat_q[i], epc, word(epc)); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat = 3;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    repeat (5) step();
    ncmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin nfail++;
      $display("FAIL mr_pre got %0h/%0h exp 1/0", inst_valid, inst_pc); end
    rst = 1'b0;
    #1;
    ncmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
    begin nfail++;
      $display("FAIL mr_req got %0h/%0h exp 1/0",
               imem_req_valid, imem_req_addr); end
    ncmp++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 ||
                inst_data !== 32'h0) begin nfail++;
      $display("FAIL mr_out got %0h/%0h/%0h exp 0/0/0",
               inst_valid, inst_pc, inst_data); end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    dpc_q.delete();
    ddat_q.delete();
    lat = 1;
    inst_ready = 1'b1;
    repeat (6) step();
    ncmp++; if (dpc_q.size() < 2 || dpc_q[0] !== 32'h0 ||
                ddat_q[0] !== word(32'h0) || dpc_q[1] !== 32'h4) begin
      nfail++;
      $display("FAIL mr_after got n=%0d exp 0,4", dpc_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_resp_pop();
    test_random_ready();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
